regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (WEN/wsel/wdat) between two writeback sources. Source A is the in-order pipeline writeback, which has priority and no backpressure. Source B is a long-latency unit (mult/div or cache-miss load return) with a valid/ready handshake. The block also holds a 32-entry pending-write scoreboard, so hazard logic can see registers still owed by B, and a starvation guard that stalls the pipeline one cycle so B can commit.

Parameters:
STARVE_LIMIT, 4, consecutive blocked cycles for B before a forced grant (legal range 1..15)

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  asynchronous reset, active-high
a_wen  in  1  pipeline writeback request
a_wsel  in  5  pipeline destination register
a_wdat  in  32  pipeline write data
b_valid  in  1  long-latency unit write request; held high until handshake
b_wsel  in  5  long-latency destination register
b_wdat  in  32  long-latency write data
b_ready  out  1  B grant; handshake = b_valid && b_ready
rsv_en  in  1  reserve a destination at multicycle-op issue
rsv_sel  in  5  register to reserve
chk_sel1  in  5  hazard lookup, source 1
chk_sel2  in  5  hazard lookup, source 2
chk_busy1  out  1  chk_sel1 has a pending B write
chk_busy2  out  1  chk_sel2 has a pending B write
pipe_stall  out  1  freeze pipeline writeback this cycle
rf_wen  out  1  register-file write enable
rf_wsel  out  5  register-file write select
rf_wdat  out  32  register-file write data

Behaviour:
- State machine (registered) has three states:
  - IDLE: no B request is blocked.
  - WAIT: B is blocked and being counted.
  - FORCE: one-cycle forced grant to B.
- "A claims port" = a_wen && a_wsel != 0. An A write to r0 never blocks B.
- Grant rules (combinational from state and inputs):
  - In FORCE: pipe_stall=1, b_ready=1, A ignored. The pipeline holds its writeback, so A is not lost.
  - Otherwise: pipe_stall=0. If A claims the port, A is granted and b_ready=0. If not, b_ready=1.
- Write port outputs:
  - rf_wsel/rf_wdat mux the granted source. With no grant they select B's inputs.
  - rf_wen = granted source valid && its wsel != 0.
  - A B handshake with b_wsel=0 completes with rf_wen=0.
- Blocked counter (width 4):
  - On each posedge where b_valid && !b_ready, the counter increments.
  - It clears on a B handshake or when b_valid=0.
- Transitions:
  - IDLE→WAIT when B is blocked.
  - WAIT→FORCE at the edge where B is blocked and count==STARVE_LIMIT-1, i.e. after STARVE_LIMIT blocked cycles.
  - WAIT→IDLE on handshake.
  - FORCE→IDLE unconditionally, and the counter clears.
  - If b_valid drops in WAIT (protocol violation), return to IDLE and clear the counter.
- Scoreboard: busy[31:0].
  - Set at posedge when rsv_en and rsv_sel != 0.
  - Cleared at posedge on a B handshake for b_wsel.
  - Same-register set and clear in one cycle: set wins.
  - Reserving an already-busy register leaves it busy (no count).
  - A writes never clear busy.
  - busy[0] is constant 0.
- chk_busyN = busy[chk_selN], combinational, same cycle. No bypass: a clear or set takes effect the next cycle.
- Register file captures on negedge, so a granted write is visible to reads in the following cycle.
- Reset (async, rst=1): state=IDLE, counter=0, busy=0.
  - Outputs then follow the grant rules with state IDLE: pipe_stall=0, b_ready=!(A claims), rf_wen per the rules above.
  - Reset asserted during FORCE aborts the forced grant. Any B handshake not completed before reset is lost.

Test Plan:
- Reset then idle: rst=1 with inputs low → rf_wen=0, b_ready=1, pipe_stall=0, chk_busy1/2=0; assert reset mid-FORCE → next cycle state IDLE, pipe_stall=0.
- A only: a_wen=1, a_wsel=5, a_wdat=0xDEADBEEF → rf_wen=1, rf_wsel=5, rf_wdat=0xDEADBEEF, same cycle; a_wsel=0 → rf_wen=0 and a simultaneous B (b_wsel=7, data 0x11) is granted.
- Contention, STARVE_LIMIT=4:
  - Stimulus: A writes every cycle; b_valid held from cycle 0 with b_wsel=9.
  - Cycles 0-3: b_ready=0.
  - Cycle 4: pipe_stall=1, b_ready=1, rf_wsel=9.
  - Cycle 5: A granted again and counter=0.
- Scoreboard: rsv_en with rsv_sel=12 → next cycle chk_busy1=1 for chk_sel1=12. B handshake to 12 → following cycle chk_busy1=0. rsv_sel=0 → busy stays 0.
- Simultaneous reserve and clear: rsv_sel=12 and B handshake b_wsel=12 in the same cycle → busy[12]=1 afterwards.
- B write to r0: b_valid, b_wsel=0, A idle → b_ready=1, rf_wen=0, no busy change, counter stays 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) has priority over a
// long-latency source (B), with a pending-write scoreboard and a starvation guard.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_wen_i,
  input  logic [4:0]  a_wsel_i,
  input  logic [31:0] a_wdat_i,
  input  logic        b_valid_i,
  input  logic [4:0]  b_wsel_i,
  input  logic [31:0] b_wdat_i,
  output logic        b_ready_o,
  input  logic        rsv_en_i,
  input  logic [4:0]  rsv_sel_i,
  input  logic [4:0]  chk_sel1_i,
  input  logic [4:0]  chk_sel2_i,
  output logic        chk_busy1_o,
  output logic        chk_busy2_o,
  output logic        pipe_stall_o,
  output logic        rf_wen_o,
  output logic [4:0]  rf_wsel_o,
  output logic [31:0] rf_wdat_o
);

  // state | meaning
  // IDLE  | no B request is blocked
  // WAIT  | B is blocked, blk_cnt_q counts blocked cycles
  // FORCE | one-cycle forced grant to B, pipeline writeback stalled
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(STARVE_LIMIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  blk_cnt_q, blk_cnt_d;
  logic [31:0] busy_q, busy_d;

  logic a_claims;
  logic a_grant;
  logic b_blocked;
  logic b_hshake;

  assign a_claims  = a_wen_i && (a_wsel_i != 5'd0);
  assign b_blocked = b_valid_i && !b_ready_o;
  assign b_hshake  = b_valid_i && b_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      blk_cnt_q <= 4'd0;
      busy_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      blk_cnt_q <= blk_cnt_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    blk_cnt_d = b_blocked ? blk_cnt_q + 4'd1 : 4'd0;
    unique case (state_q)
      IDLE: begin
        if (b_blocked) state_d = (blk_cnt_q == CNT_LAST) ? FORCE : WAIT;
      end
      WAIT: begin
        if (!b_valid_i || b_hshake)                state_d = IDLE;
        else if (blk_cnt_q == CNT_LAST)            state_d = FORCE;
      end
      FORCE: begin
        state_d   = IDLE;
        blk_cnt_d = 4'd0;
      end
      default: begin
        state_d   = IDLE;
        blk_cnt_d = 4'd0;
      end
    endcase

    // Clear first so a same-cycle reservation of the same register wins.
    busy_d = busy_q;
    if (b_hshake) busy_d[b_wsel_i] = 1'b0;
    if (rsv_en_i) busy_d[rsv_sel_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pipe_stall_o = (state_q == FORCE);
    a_grant      = !pipe_stall_o && a_claims;
    b_ready_o    = !a_grant;
    rf_wsel_o    = a_grant ? a_wsel_i : b_wsel_i;
    rf_wdat_o    = a_grant ? a_wdat_i : b_wdat_i;
    rf_wen_o     = a_grant || (b_hshake && (b_wsel_i != 5'd0));
    chk_busy1_o  = busy_q[chk_sel1_i];
    chk_busy2_o  = busy_q[chk_sel2_i];
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: each driven cycle pushes its expected outputs, a negedge
// monitor pops and compares them.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_wen;
  logic [4:0]  a_wsel;
  logic [31:0] a_wdat;
  logic        b_valid;
  logic [4:0]  b_wsel;
  logic [31:0] b_wdat;
  logic        b_ready;
  logic        rsv_en;
  logic [4:0]  rsv_sel;
  logic [4:0]  chk_sel1;
  logic [4:0]  chk_sel2;
  logic        chk_busy1;
  logic        chk_busy2;
  logic        pipe_stall;
  logic        rf_wen;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        b_ready;
    logic        pipe_stall;
    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic        busy1;
    logic        busy2;
  } exp_t;

  exp_t exp_q[$];

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .a_wen_i      (a_wen),
    .a_wsel_i     (a_wsel),
    .a_wdat_i     (a_wdat),
    .b_valid_i    (b_valid),
    .b_wsel_i     (b_wsel),
    .b_wdat_i     (b_wdat),
    .b_ready_o    (b_ready),
    .rsv_en_i     (rsv_en),
    .rsv_sel_i    (rsv_sel),
    .chk_sel1_i   (chk_sel1),
    .chk_sel2_i   (chk_sel2),
    .chk_busy1_o  (chk_busy1),
    .chk_busy2_o  (chk_busy2),
    .pipe_stall_o (pipe_stall),
    .rf_wen_o     (rf_wen),
    .rf_wsel_o    (rf_wsel),
    .rf_wdat_o    (rf_wdat)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq("b_ready",    32'(b_ready),    32'(e.b_ready));
      check_eq("pipe_stall", 32'(pipe_stall), 32'(e.pipe_stall));
      check_eq("rf_wen",     32'(rf_wen),     32'(e.rf_wen));
      check_eq("rf_wsel",    32'(rf_wsel),    32'(e.rf_wsel));
      check_eq("rf_wdat",    rf_wdat,         e.rf_wdat);
      check_eq("chk_busy1",  32'(chk_busy1),  32'(e.busy1));
      check_eq("chk_busy2",  32'(chk_busy2),  32'(e.busy2));
    end
  end

  // Start a new cycle: inputs change 1ns after the rising edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_wen = 1'b0; a_wsel = 5'd0; a_wdat = 32'd0;
    b_valid = 1'b0; b_wsel = 5'd0; b_wdat = 32'd0;
    rsv_en = 1'b0; rsv_sel = 5'd0;
    chk_sel1 = 5'd0; chk_sel2 = 5'd0;
  endtask

  task automatic push_exp(input logic rdy, input logic stall, input logic wen,
                          input logic [4:0] wsel, input logic [31:0] wdat,
                          input logic bz1, input logic bz2);
    exp_t e;
    e.b_ready = rdy; e.pipe_stall = stall; e.rf_wen = wen;
    e.rf_wsel = wsel; e.rf_wdat = wdat; e.busy1 = bz1; e.busy2 = bz2;
    exp_q.push_back(e);
  endtask

  // A writes r3 every cycle while B (r9) is held valid.
  task automatic contend(input int n);
    for (int i = 0; i < n; i++) begin
      next_cyc();
      a_wen = 1'b1; a_wsel = 5'd3; a_wdat = 32'h100 + 32'(i);
      b_valid = 1'b1; b_wsel = 5'd9; b_wdat = 32'h99;
      push_exp(1'b0, 1'b0, 1'b1, 5'd3, 32'h100 + 32'(i), 1'b0, 1'b0);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Reset with idle inputs
    next_cyc();
    push_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    next_cyc();
    rst = 1'b0;
    push_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // A only
    next_cyc();
    a_wen = 1'b1; a_wsel = 5'd5; a_wdat = 32'hDEADBEEF;
    push_exp(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);

    // A to r0 does not block B
    next_cyc();
    a_wsel = 5'd0;
    b_valid = 1'b1; b_wsel = 5'd7; b_wdat = 32'h11;
    push_exp(1'b1, 1'b0, 1'b1, 5'd7, 32'h11, 1'b0, 1'b0);

    next_cyc();
    clear_inputs();
    push_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // Contention: four blocked cycles, then forced grant, then A again
    contend(4);
    next_cyc();
    push_exp(1'b1, 1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
    next_cyc();
    b_valid = 1'b0; b_wsel = 5'd0; b_wdat = 32'd0; a_wdat = 32'h105;
    push_exp(1'b0, 1'b0, 1'b1, 5'd3, 32'h105, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("cnt_after_force", 32'(dut.blk_cnt_q), 32'd0);

    // Reset asserted during the forced cycle aborts it
    contend(4);
    next_cyc();
    rst = 1'b1;
    push_exp(1'b0, 1'b0, 1'b1, 5'd3, 32'h103, 1'b0, 1'b0);
    next_cyc();
    rst = 1'b0;
    push_exp(1'b0, 1'b0, 1'b1, 5'd3, 32'h103, 1'b0, 1'b0);
    next_cyc();
    a_wen = 1'b0; a_wsel = 5'd0;
    push_exp(1'b1, 1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0);

    // B drops valid while waiting: count restarts from zero
    next_cyc();
    clear_inputs();
    push_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    contend(2);
    next_cyc();
    b_valid = 1'b0; b_wsel = 5'd0; b_wdat = 32'd0; a_wdat = 32'h200;
    push_exp(1'b0, 1'b0, 1'b1, 5'd3, 32'h200, 1'b0, 1'b0);
    contend(4);
    next_cyc();
    push_exp(1'b1, 1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0);

    // Scoreboard: reserve r12, no same-cycle bypass
    next_cyc();
    clear_inputs();
    rsv_en = 1'b1; rsv_sel = 5'd12; chk_sel1 = 5'd12; chk_sel2 = 5'd12;
    push_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    next_cyc();
    rsv_en = 1'b0; rsv_sel = 5'd0; chk_sel2 = 5'd0;
    push_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    next_cyc();
    b_valid = 1'b1; b_wsel = 5'd12; b_wdat = 32'h1234;
    push_exp(1'b1, 1'b0, 1'b1, 5'd12, 32'h1234, 1'b1, 1'b0);
    next_cyc();
    b_valid = 1'b0; b_wsel = 5'd0; b_wdat = 32'd0;
    rsv_en = 1'b1; rsv_sel = 5'd0;
    push_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    next_cyc();
    rsv_en = 1'b0;
    push_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check_eq("busy_r0", 32'(dut.busy_q), 32'd0);

    // Simultaneous reserve and clear of r12: reserve wins
    next_cyc();
    rsv_en = 1'b1; rsv_sel = 5'd12;
    b_valid = 1'b1; b_wsel = 5'd12; b_wdat = 32'h77;
    chk_sel2 = 5'd12;
    push_exp(1'b1, 1'b0, 1'b1, 5'd12, 32'h77, 1'b0, 1'b0);
    next_cyc();
    clear_inputs();
    chk_sel1 = 5'd12; chk_sel2 = 5'd12;
    a_wen = 1'b1; a_wsel = 5'd12; a_wdat = 32'hA5A5A5A5;
    push_exp(1'b0, 1'b0, 1'b1, 5'd12, 32'hA5A5A5A5, 1'b1, 1'b1);
    next_cyc();
    a_wen = 1'b0; a_wsel = 5'd0; a_wdat = 32'd0;
    push_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);

    // B write to r0: handshake completes without a register write
    next_cyc();
    b_valid = 1'b1; b_wsel = 5'd0; b_wdat = 32'h55;
    push_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'h55, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("cnt_b_r0", 32'(dut.blk_cnt_q), 32'd0);
    next_cyc();
    clear_inputs();
    chk_sel1 = 5'd12;
    push_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
